// File: rtl/dma_chan_regfile.sv
// Per-channel address/word-count register file for an 8237A-style DMA controller.
// Build option: define DMA_AUTOINIT_EN to add base registers and honour autoinit reload on TC.
module dma_chan_regfile #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int BW  = 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           wr_en,
  input  logic           rd_en,
  input  logic [2:0]     reg_sel,
  input  logic [CW-1:0]  ch_sel,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  input  logic           xfer,
  input  logic [CW-1:0]  xfer_ch,
  input  logic [NCH-1:0] req_in,
  output logic [AW-1:0]  cur_addr,
  output logic [NCH-1:0] tc,
  output logic [NCH-1:0] ch_mask
);

  localparam int NB = AW / 8;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] SEL_ADDR = 3'd0;
  localparam logic [2:0] SEL_CNT  = 3'd1;
  localparam logic [2:0] SEL_MODE = 3'd2;
  localparam logic [2:0] SEL_STAT = 3'd3;
  localparam logic [2:0] SEL_PCLR = 3'd4;
  localparam logic [2:0] SEL_MCLR = 3'd5;

  if (BW != 8 || NCH < 1 || NCH > 4 || AW < 8 || AW > 32 || (AW % 8) != 0) begin : g_param_check
    $error("dma_chan_regfile: illegal NCH/AW/BW");
  end

  logic [AW-1:0]  cur_addr_q [NCH];
  logic [AW-1:0]  cur_cnt_q  [NCH];
`ifdef DMA_AUTOINIT_EN
  logic [AW-1:0]  base_addr_q [NCH];
  logic [AW-1:0]  base_cnt_q  [NCH];
`endif
  logic [2:0]     mode_q [NCH];
  logic [PW-1:0]  ptr;
  logic [NCH-1:0] req_q;
  logic [NCH-1:0] tcflag;

  logic           ch_ok;
  logic           xch_ok;
  logic           ptr_access;
  logic [PW-1:0]  ptr_next;
  logic           do_xfer;
  logic           is_tc;
  logic           autoinit;
  logic [7:0]     status_byte;
  logic [7:0]     rd_byte;

  function automatic logic [7:0] get_byte(input logic [AW-1:0] v, input logic [PW-1:0] p);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < NB; i++)
      if (p == PW'(i)) b = v[i*8 +: 8];
    return b;
  endfunction

  function automatic logic [AW-1:0] set_byte(input logic [AW-1:0] v, input logic [PW-1:0] p,
                                             input logic [7:0] b);
    logic [AW-1:0] r;
    r = v;
    for (int i = 0; i < NB; i++)
      if (p == PW'(i)) r[i*8 +: 8] = b;
    return r;
  endfunction

  always_comb begin
    ch_ok      = int'(ch_sel) < NCH;
    xch_ok     = int'(xfer_ch) < NCH;
    ptr_access = (wr_en || rd_en) && (reg_sel == SEL_ADDR || reg_sel == SEL_CNT);
    ptr_next   = (ptr == PW'(NB - 1)) ? '0 : ptr + 1'b1;
    do_xfer    = xfer && xch_ok && !ch_mask[xfer_ch];
    is_tc      = do_xfer && (cur_cnt_q[xfer_ch] == '0);
`ifdef DMA_AUTOINIT_EN
    autoinit   = mode_q[xfer_ch][1];
`else
    autoinit   = 1'b0;
`endif
    cur_addr   = xch_ok ? cur_addr_q[xfer_ch] : '0;

    status_byte = '0;
    for (int c = 0; c < NCH; c++) begin
      status_byte[c]     = tcflag[c];
      status_byte[4 + c] = req_q[c];
    end

    rd_byte = '0;
    case (reg_sel)
      SEL_ADDR: if (ch_ok) rd_byte = get_byte(cur_addr_q[ch_sel], ptr);
      SEL_CNT:  if (ch_ok) rd_byte = get_byte(cur_cnt_q[ch_sel], ptr);
      SEL_MODE: if (ch_ok) rd_byte = {5'b0, mode_q[ch_sel]};
      SEL_STAT: rd_byte = status_byte;
      default:  rd_byte = '0;
    endcase
  end

  // Later assignments override earlier ones: status-read clear < TC set, xfer step < CPU write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int c = 0; c < NCH; c++) begin
        cur_addr_q[c]  <= '0;
        cur_cnt_q[c]   <= '0;
`ifdef DMA_AUTOINIT_EN
        base_addr_q[c] <= '0;
        base_cnt_q[c]  <= '0;
`endif
        mode_q[c]      <= '0;
      end
      ptr     <= '0;
      req_q   <= '0;
      tcflag  <= '0;
      rdata   <= '0;
      tc      <= '0;
      ch_mask <= '1;
    end else if (wr_en && reg_sel == SEL_MCLR) begin
      for (int c = 0; c < NCH; c++) begin
        cur_addr_q[c]  <= '0;
        cur_cnt_q[c]   <= '0;
`ifdef DMA_AUTOINIT_EN
        base_addr_q[c] <= '0;
        base_cnt_q[c]  <= '0;
`endif
        mode_q[c]      <= '0;
      end
      ptr     <= '0;
      req_q   <= '0;
      tcflag  <= '0;
      rdata   <= '0;
      tc      <= '0;
      ch_mask <= '1;
    end else begin
      req_q <= req_in;
      tc    <= '0;

      if (ptr_access) ptr <= ptr_next;
      if (wr_en && reg_sel == SEL_PCLR) ptr <= '0;

      if (rd_en) rdata <= rd_byte;
      if (rd_en && reg_sel == SEL_STAT) tcflag <= '0;

      if (do_xfer) begin
        if (is_tc) begin
          tc[xfer_ch]     <= 1'b1;
          tcflag[xfer_ch] <= 1'b1;
        end
        if (is_tc && autoinit) begin
`ifdef DMA_AUTOINIT_EN
          cur_addr_q[xfer_ch] <= base_addr_q[xfer_ch];
          cur_cnt_q[xfer_ch]  <= base_cnt_q[xfer_ch];
`endif
        end else begin
          if (!mode_q[xfer_ch][2])
            cur_addr_q[xfer_ch] <= mode_q[xfer_ch][0] ? cur_addr_q[xfer_ch] - 1'b1
                                                      : cur_addr_q[xfer_ch] + 1'b1;
          cur_cnt_q[xfer_ch] <= cur_cnt_q[xfer_ch] - 1'b1;
          if (is_tc) ch_mask[xfer_ch] <= 1'b1;
        end
      end

      if (wr_en && ch_ok) begin
        case (reg_sel)
          SEL_ADDR: begin
            cur_addr_q[ch_sel]  <= set_byte(cur_addr_q[ch_sel], ptr, wdata);
`ifdef DMA_AUTOINIT_EN
            base_addr_q[ch_sel] <= set_byte(base_addr_q[ch_sel], ptr, wdata);
`endif
          end
          SEL_CNT: begin
            cur_cnt_q[ch_sel]  <= set_byte(cur_cnt_q[ch_sel], ptr, wdata);
`ifdef DMA_AUTOINIT_EN
            base_cnt_q[ch_sel] <= set_byte(base_cnt_q[ch_sel], ptr, wdata);
`endif
            if (ptr_next == '0) ch_mask[ch_sel] <= 1'b0;
          end
          SEL_MODE: mode_q[ch_sel] <= wdata[2:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_chan_regfile.sv
// Directed bench for dma_chan_regfile (NCH=4, AW=16) with hand-computed expectations.
module tb_dma_chan_regfile;

  logic        CLK;
  logic        RESET;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  reg_sel;
  logic [1:0]  ch_sel;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        xfer;
  logic [1:0]  xfer_ch;
  logic [3:0]  req_in;
  logic [15:0] cur_addr;
  logic [3:0]  tc;
  logic [3:0]  ch_mask;

  int checks;
  int failures;

  dma_chan_regfile #(.NCH(4), .AW(16), .BW(8)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .rd_en(rd_en), .reg_sel(reg_sel),
    .ch_sel(ch_sel), .wdata(wdata), .rdata(rdata), .xfer(xfer), .xfer_ch(xfer_ch),
    .req_in(req_in), .cur_addr(cur_addr), .tc(tc), .ch_mask(ch_mask)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] rs, input logic [1:0] ch, input logic [7:0] d);
    wr_en = 1'b1; reg_sel = rs; ch_sel = ch; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] rs, input logic [1:0] ch);
    rd_en = 1'b1; reg_sel = rs; ch_sel = ch;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic xf(input logic [1:0] ch);
    xfer = 1'b1; xfer_ch = ch;
    tick();
    xfer = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    RESET = 1'b0; wr_en = 1'b0; rd_en = 1'b0; reg_sel = 3'd0; ch_sel = 2'd0;
    wdata = 8'h00; xfer = 1'b0; xfer_ch = 2'd0; req_in = 4'h0;
    repeat (2) tick();
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_tc", tc, 4'h0);
    chk("reset_mask", ch_mask, 4'hF);
    chk("reset_addr", cur_addr, 16'h0000);
    RESET = 1'b1;
    tick();

    // ch1 incrementing, count 2 -> TC on third transfer
    wr(3'd0, 2'd1, 8'h34); wr(3'd0, 2'd1, 8'h12);
    wr(3'd1, 2'd1, 8'h02); wr(3'd1, 2'd1, 8'h00);
    wr(3'd2, 2'd1, 8'h00);
    chk("ch1_unmask", ch_mask, 4'b1101);
    xfer_ch = 2'd1; #1;
    chk("ch1_addr0", cur_addr, 16'h1234);
    xf(2'd1);
    chk("ch1_addr1", cur_addr, 16'h1235);
    chk("ch1_tc1", tc, 4'h0);
    xf(2'd1);
    chk("ch1_addr2", cur_addr, 16'h1236);
    xf(2'd1);
    chk("ch1_addr3", cur_addr, 16'h1237);
    chk("ch1_tc3", tc, 4'b0010);
    chk("ch1_mask", ch_mask, 4'hF);
    xf(2'd1);
    chk("ch1_addr4", cur_addr, 16'h1237);
    chk("ch1_tc4", tc, 4'h0);
    rd(3'd1, 2'd1);
    chk("ch1_cnt_lo", rdata, 8'hFF);
    rd(3'd1, 2'd1);
    chk("ch1_cnt_hi", rdata, 8'hFF);
    rd(3'd3, 2'd0);
    chk("ch1_status", rdata, 8'h02);

    // ch0 decrementing from zero: address and count wrap
    wr(3'd2, 2'd0, 8'h01);
    wr(3'd0, 2'd0, 8'h00); wr(3'd0, 2'd0, 8'h00);
    wr(3'd1, 2'd0, 8'h00); wr(3'd1, 2'd0, 8'h00);
    xf(2'd0);
    chk("ch0_addr", cur_addr, 16'hFFFF);
    chk("ch0_tc", tc, 4'b0001);
    rd(3'd1, 2'd0);
    chk("ch0_cnt_lo", rdata, 8'hFF);
    rd(3'd1, 2'd0);
    chk("ch0_cnt_hi", rdata, 8'hFF);
    rd(3'd2, 2'd0);
    chk("ch0_mode", rdata, 8'h01);
    rd(3'd3, 2'd0);
    chk("ch0_status1", rdata, 8'h01);
    rd(3'd3, 2'd0);
    chk("ch0_status2", rdata, 8'h00);

    // ch2 autoinit, count 1 -> TC on second transfer
    wr(3'd2, 2'd2, 8'h02);
    wr(3'd0, 2'd2, 8'h00); wr(3'd0, 2'd2, 8'h40);
    wr(3'd1, 2'd2, 8'h01); wr(3'd1, 2'd2, 8'h00);
    xf(2'd2);
    chk("ch2_addr1", cur_addr, 16'h4001);
    chk("ch2_tc1", tc, 4'h0);
    xf(2'd2);
    chk("ch2_tc2", tc, 4'b0100);
`ifdef DMA_AUTOINIT_EN
    chk("ch2_addr2", cur_addr, 16'h4000);
    chk("ch2_mask", ch_mask[2], 1'b0);
    rd(3'd1, 2'd2);
    chk("ch2_cnt_lo", rdata, 8'h01);
    rd(3'd1, 2'd2);
    chk("ch2_cnt_hi", rdata, 8'h00);
`else
    chk("ch2_addr2", cur_addr, 16'h4002);
    chk("ch2_mask", ch_mask[2], 1'b1);
    rd(3'd1, 2'd2);
    chk("ch2_cnt_lo", rdata, 8'hFF);
    rd(3'd1, 2'd2);
    chk("ch2_cnt_hi", rdata, 8'hFF);
`endif
    rd(3'd3, 2'd0);
    chk("ch2_status", rdata, 8'h04);
    rd(3'd6, 2'd0);
    chk("undef_read", rdata, 8'h00);

    // byte pointer clear between address byte writes
    wr(3'd0, 2'd3, 8'h55);
    wr(3'd4, 2'd0, 8'h00);
    wr(3'd0, 2'd3, 8'hAA);
    xfer_ch = 2'd3; #1;
    chk("ptr_addr", cur_addr, 16'h00AA);
    wr(3'd4, 2'd0, 8'h13);
    rd(3'd0, 2'd3);
    chk("ptr_rd_lo", rdata, 8'hAA);
    rd(3'd0, 2'd3);
    chk("ptr_rd_hi", rdata, 8'h00);

    // status read colliding with ch3 TC: set wins
    req_in = 4'b1010;
    wr(3'd1, 2'd3, 8'h00); wr(3'd1, 2'd3, 8'h00);
    rd_en = 1'b1; reg_sel = 3'd3; xfer = 1'b1; xfer_ch = 2'd3;
    tick();
    rd_en = 1'b0; xfer = 1'b0;
    chk("coll_status", rdata, 8'hA0);
    chk("coll_tc", tc, 4'b1000);
    rd(3'd3, 2'd0);
    chk("coll_status2", rdata, 8'hA8);
    chk("coll_addr", cur_addr, 16'h00AB);

    // master clear
    wr(3'd5, 2'd0, 8'h00);
    chk("mclr_rdata", rdata, 8'h00);
    chk("mclr_mask", ch_mask, 4'hF);
    chk("mclr_addr", cur_addr, 16'h0000);

    // async reset while a TC pulse is active
    wr(3'd1, 2'd0, 8'h00); wr(3'd1, 2'd0, 8'h00);
    rd(3'd3, 2'd0);
    xf(2'd0);
    chk("pre_rst_tc", tc, 4'b0001);
    chk("pre_rst_rdata", rdata, 8'hA0);
    #2 RESET = 1'b0;
    #1;
    chk("async_tc", tc, 4'h0);
    chk("async_mask", ch_mask, 4'hF);
    chk("async_rdata", rdata, 8'h00);
    chk("async_addr", cur_addr, 16'h0000);
    tick();
    RESET = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
